// File: rtl/ex_stage_if.sv
// ID/EX inputs and EX/MEM outputs of the execute stage, bundled as one port.
// The master side is whoever drives the ID/EX register; ex_stage is the slave.
interface ex_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            bit_th_in;
    logic            m_bit_in;
    logic [4:0]      read_reg1_in;
    logic [4:0]      read_reg2_in;
    logic [4:0]      write_reg_in;
    logic [2:0]      funct3_in;
    logic [6:0]      opcode_in;
    logic [XLEN-1:0] imm_in;
    logic [XLEN-1:0] read_data1_in;
    logic [XLEN-1:0] read_data2_in;
    logic            register_write_valid_in;
    logic [3:0]      data_write_byte_in;
    logic [XLEN-1:0] instruction_addr_in;
    logic            mem_stall;

    logic            EXMEM_valid;
    logic [XLEN-1:0] EXMEM_alu_result;
    logic [XLEN-1:0] EXMEM_store_data;
    logic [4:0]      EXMEM_write_reg;
    logic            EXMEM_register_write_valid;
    logic [3:0]      EXMEM_data_write_byte;
    logic [2:0]      EXMEM_funct3;
    logic [6:0]      EXMEM_opcode;
    logic            pc_replace;
    logic [XLEN-1:0] pc_target;
    logic            ex_stall;

    modport master (
        output in_valid, bit_th_in, m_bit_in, read_reg1_in, read_reg2_in, write_reg_in,
               funct3_in, opcode_in, imm_in, read_data1_in, read_data2_in,
               register_write_valid_in, data_write_byte_in, instruction_addr_in, mem_stall,
        input  EXMEM_valid, EXMEM_alu_result, EXMEM_store_data, EXMEM_write_reg,
               EXMEM_register_write_valid, EXMEM_data_write_byte, EXMEM_funct3,
               EXMEM_opcode, pc_replace, pc_target, ex_stall
    );

    modport slave (
        input  in_valid, bit_th_in, m_bit_in, read_reg1_in, read_reg2_in, write_reg_in,
               funct3_in, opcode_in, imm_in, read_data1_in, read_data2_in,
               register_write_valid_in, data_write_byte_in, instruction_addr_in, mem_stall,
        output EXMEM_valid, EXMEM_alu_result, EXMEM_store_data, EXMEM_write_reg,
               EXMEM_register_write_valid, EXMEM_data_write_byte, EXMEM_funct3,
               EXMEM_opcode, pc_replace, pc_target, ex_stall
    );
endinterface

// File: rtl/ex_stage.sv
// RV32I execute stage with branch resolution and an iterative shift-add MUL.
// Results land in the EX/MEM register; taken branches/jumps pulse pc_replace.
module ex_stage #(
    parameter int XLEN       = 32,
    parameter int MUL_CYCLES = 32
) (
    input logic       clk,
    input logic       reset,
    ex_stage_if.slave bus
);
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam int         CW        = $clog2(MUL_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_e;

    mul_state_e      state, state_next;
    logic [CW-1:0]   count;
    logic [XLEN-1:0] acc, mcand, mplier;
    logic [4:0]      mul_rd;
    logic            mul_rwv;

    logic            accept, live, mul_start;
    logic [XLEN-1:0] rs1, rs2, alu_b, sum, alu_out, result, target;
    logic            rwv, taken;
    logic            unused_bits;

    assign rs1 = bus.read_data1_in;
    assign rs2 = bus.read_data2_in;
    assign unused_bits = ^{bus.read_reg1_in, bus.read_reg2_in};

    // An instruction accepted while the previous one redirects is on the wrong path.
    assign accept    = bus.in_valid && !bus.ex_stall && (state == IDLE);
    assign live      = accept && !bus.pc_replace;
    assign mul_start = live && (bus.opcode_in == OP_R) && bus.m_bit_in && (bus.funct3_in == 3'b000);

    // NOTE: plain assignments and a default for every output keep these blocks latch-free.
    always_comb begin
        alu_b   = (bus.opcode_in == OP_R) ? rs2 : bus.imm_in;
        sum     = rs1 + alu_b;
        alu_out = '0;
        unique case (bus.funct3_in)
            3'b000: alu_out = (bus.opcode_in == OP_R && bus.bit_th_in) ? rs1 - alu_b : sum;
            3'b001: alu_out = rs1 << alu_b[4:0];
            3'b010: alu_out = {{(XLEN-1){1'b0}}, $signed(rs1) < $signed(alu_b)};
            3'b011: alu_out = {{(XLEN-1){1'b0}}, rs1 < alu_b};
            3'b100: alu_out = rs1 ^ alu_b;
            3'b101: begin
                if (bus.bit_th_in) alu_out = $signed(rs1) >>> alu_b[4:0];
                else               alu_out = rs1 >> alu_b[4:0];
            end
            3'b110: alu_out = rs1 | alu_b;
            3'b111: alu_out = rs1 & alu_b;
        endcase
    end

    always_comb begin
        result = '0;
        rwv    = bus.register_write_valid_in;
        taken  = 1'b0;
        target = bus.instruction_addr_in + bus.imm_in;
        unique case (bus.opcode_in)
            OP_R:              result = bus.m_bit_in ? '0 : alu_out;
            OP_I:              result = alu_out;
            OP_LOAD, OP_STORE: result = sum;
            OP_LUI:            result = bus.imm_in;
            OP_AUIPC:          result = bus.instruction_addr_in + bus.imm_in;
            OP_JAL: begin
                result = bus.instruction_addr_in + XLEN'(4);
                taken  = 1'b1;
            end
            OP_JALR: begin
                result = bus.instruction_addr_in + XLEN'(4);
                taken  = 1'b1;
                target = sum & ~XLEN'(1);
            end
            OP_BRANCH: begin
                rwv = 1'b0;
                unique case (bus.funct3_in)
                    3'b000:  taken = (rs1 == rs2);
                    3'b001:  taken = (rs1 != rs2);
                    3'b100:  taken = $signed(rs1) <  $signed(rs2);
                    3'b101:  taken = $signed(rs1) >= $signed(rs2);
                    3'b110:  taken = rs1 <  rs2;
                    3'b111:  taken = rs1 >= rs2;
                    default: taken = 1'b0;
                endcase
            end
            default: rwv = 1'b0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (mul_start) state_next = BUSY;
            BUSY: if (count == CW'(MUL_CYCLES - 1)) state_next = DONE;
            DONE: if (!bus.mem_stall) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.ex_stall = (state == BUSY) ? 1'b1 : bus.mem_stall;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count   <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            mul_rd  <= '0;
            mul_rwv <= 1'b0;
        end else if (state == IDLE) begin
            if (mul_start) begin
                count   <= '0;
                acc     <= '0;
                mcand   <= rs1;
                mplier  <= rs2;
                mul_rd  <= bus.write_reg_in;
                mul_rwv <= bus.register_write_valid_in;
            end
        end else if (state == BUSY) begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.EXMEM_valid                <= 1'b0;
            bus.EXMEM_alu_result           <= '0;
            bus.EXMEM_store_data           <= '0;
            bus.EXMEM_write_reg            <= '0;
            bus.EXMEM_register_write_valid <= 1'b0;
            bus.EXMEM_data_write_byte      <= '0;
            bus.EXMEM_funct3               <= '0;
            bus.EXMEM_opcode               <= '0;
            bus.pc_replace                 <= 1'b0;
            bus.pc_target                  <= '0;
        end else if (!bus.mem_stall) begin
            if (state == DONE) begin
                bus.EXMEM_valid                <= 1'b1;
                bus.EXMEM_alu_result           <= acc;
                bus.EXMEM_store_data           <= '0;
                bus.EXMEM_write_reg            <= mul_rd;
                bus.EXMEM_register_write_valid <= mul_rwv;
                bus.EXMEM_data_write_byte      <= '0;
                bus.EXMEM_funct3               <= 3'b000;
                bus.EXMEM_opcode               <= OP_R;
                bus.pc_replace                 <= 1'b0;
                bus.pc_target                  <= '0;
            end else if (live && !mul_start) begin
                bus.EXMEM_valid                <= 1'b1;
                bus.EXMEM_alu_result           <= result;
                bus.EXMEM_store_data           <= rs2;
                bus.EXMEM_write_reg            <= bus.write_reg_in;
                bus.EXMEM_register_write_valid <= rwv;
                bus.EXMEM_data_write_byte      <= bus.data_write_byte_in;
                bus.EXMEM_funct3               <= bus.funct3_in;
                bus.EXMEM_opcode               <= bus.opcode_in;
                bus.pc_replace                 <= taken;
                bus.pc_target                  <= taken ? target : '0;
            end else begin
                // Bubble: idle cycle, squashed instruction, MUL start or MUL in progress.
                bus.EXMEM_valid                <= 1'b0;
                bus.EXMEM_register_write_valid <= 1'b0;
                bus.EXMEM_data_write_byte      <= '0;
                bus.pc_replace                 <= 1'b0;
                bus.pc_target                  <= '0;
            end
        end
    end
endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: a table of single-cycle ops, then hand-written
// sequences for squash, MUL latency, reset mid-MUL and mem_stall holds.
module tb_ex_stage;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam int         NVEC      = 24;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        bt;
        logic        mb;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic        rwv_in;
        logic        chk_res;
        logic [31:0] exp_res;
        logic        exp_rwv;
        logic        exp_rep;
        logic [31:0] exp_tgt;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[NVEC];

    ex_stage_if #(.XLEN(32)) bus();

    ex_stage #(.XLEN(32), .MUL_CYCLES(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v, input logic [4:0] rd);
        bus.opcode_in               = v.op;
        bus.funct3_in               = v.f3;
        bus.bit_th_in               = v.bt;
        bus.m_bit_in                = v.mb;
        bus.read_data1_in           = v.rs1;
        bus.read_data2_in           = v.rs2;
        bus.imm_in                  = v.imm;
        bus.instruction_addr_in     = v.pc;
        bus.register_write_valid_in = v.rwv_in;
        bus.write_reg_in            = rd;
        bus.read_reg1_in            = 5'd1;
        bus.read_reg2_in            = 5'd2;
        bus.data_write_byte_in      = (v.op == OP_STORE) ? 4'hF : 4'h0;
    endtask

    initial begin
        vec_t v;
        //           op         f3    bt    mb    rs1           rs2           imm           pc         rwv   chk   exp_res       exp_rwv rep  exp_tgt
        vecs[0]  = '{OP_R,      3'd0, 1'b0, 1'b0, 32'd7,        32'd5,        32'd0,        32'h10,    1'b1, 1'b1, 32'd12,       1'b1, 1'b0, 32'h0};
        vecs[1]  = '{OP_R,      3'd0, 1'b1, 1'b0, 32'd5,        32'd7,        32'd0,        32'h14,    1'b1, 1'b1, 32'hFFFFFFFE, 1'b1, 1'b0, 32'h0};
        vecs[2]  = '{OP_R,      3'd5, 1'b1, 1'b0, 32'h80000000, 32'd4,        32'd0,        32'h18,    1'b1, 1'b1, 32'hF8000000, 1'b1, 1'b0, 32'h0};
        vecs[3]  = '{OP_R,      3'd5, 1'b0, 1'b0, 32'h80000000, 32'd4,        32'd0,        32'h1C,    1'b1, 1'b1, 32'h08000000, 1'b1, 1'b0, 32'h0};
        vecs[4]  = '{OP_R,      3'd2, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd1,        32'd0,        32'h20,    1'b1, 1'b1, 32'd1,        1'b1, 1'b0, 32'h0};
        vecs[5]  = '{OP_R,      3'd3, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd1,        32'd0,        32'h24,    1'b1, 1'b1, 32'd0,        1'b1, 1'b0, 32'h0};
        vecs[6]  = '{OP_R,      3'd1, 1'b0, 1'b0, 32'd1,        32'h23,       32'd0,        32'h28,    1'b1, 1'b1, 32'd8,        1'b1, 1'b0, 32'h0};
        vecs[7]  = '{OP_R,      3'd7, 1'b0, 1'b0, 32'hFF00FF00, 32'h0FF00FF0, 32'd0,        32'h2C,    1'b1, 1'b1, 32'h0F000F00, 1'b1, 1'b0, 32'h0};
        vecs[8]  = '{OP_I,      3'd0, 1'b1, 1'b0, 32'd10,       32'd99,       32'hFFFFFFFD, 32'h30,    1'b1, 1'b1, 32'd7,        1'b1, 1'b0, 32'h0};
        vecs[9]  = '{OP_I,      3'd4, 1'b0, 1'b0, 32'hF0F0F0F0, 32'd0,        32'h000000FF, 32'h34,    1'b1, 1'b1, 32'hF0F0F00F, 1'b1, 1'b0, 32'h0};
        vecs[10] = '{OP_I,      3'd6, 1'b0, 1'b0, 32'h0F,       32'd0,        32'hF0,       32'h38,    1'b1, 1'b1, 32'hFF,       1'b1, 1'b0, 32'h0};
        vecs[11] = '{OP_I,      3'd5, 1'b1, 1'b0, 32'h80000010, 32'd0,        32'h404,      32'h3C,    1'b1, 1'b1, 32'hF8000001, 1'b1, 1'b0, 32'h0};
        vecs[12] = '{OP_LOAD,   3'd2, 1'b0, 1'b0, 32'h1000,     32'd0,        32'hFFFFFFFC, 32'h40,    1'b1, 1'b1, 32'h00000FFC, 1'b1, 1'b0, 32'h0};
        vecs[13] = '{OP_LUI,    3'd0, 1'b0, 1'b0, 32'h55,       32'd0,        32'h12345000, 32'h44,    1'b1, 1'b1, 32'h12345000, 1'b1, 1'b0, 32'h0};
        vecs[14] = '{OP_AUIPC,  3'd0, 1'b0, 1'b0, 32'h55,       32'd0,        32'h1000,     32'h200,   1'b1, 1'b1, 32'h1200,     1'b1, 1'b0, 32'h0};
        vecs[15] = '{OP_JAL,    3'd0, 1'b0, 1'b0, 32'h55,       32'd0,        32'h80,       32'h300,   1'b1, 1'b1, 32'h304,      1'b1, 1'b1, 32'h380};
        vecs[16] = '{OP_JALR,   3'd0, 1'b0, 1'b0, 32'h203,      32'd0,        32'h0,        32'h40,    1'b1, 1'b1, 32'h44,       1'b1, 1'b1, 32'h202};
        vecs[17] = '{OP_BRANCH, 3'd1, 1'b0, 1'b0, 32'd1,        32'd1,        32'h10,       32'h500,   1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0};
        vecs[18] = '{OP_BRANCH, 3'd4, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFF0, 32'h600,   1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h5F0};
        vecs[19] = '{OP_BRANCH, 3'd7, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd1,        32'h8,        32'h700,   1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h708};
        vecs[20] = '{OP_BRANCH, 3'd2, 1'b0, 1'b0, 32'd3,        32'd3,        32'h8,        32'h780,   1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0};
        vecs[21] = '{OP_BRANCH, 3'd5, 1'b0, 1'b0, 32'd2,        32'd2,        32'hFFFFFF00, 32'h900,   1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h800};
        vecs[22] = '{7'h7F,     3'd0, 1'b0, 1'b0, 32'd4,        32'd4,        32'h8,        32'hA00,   1'b1, 1'b1, 32'h0,        1'b0, 1'b0, 32'h0};
        vecs[23] = '{OP_R,      3'd1, 1'b0, 1'b1, 32'd5,        32'd6,        32'h0,        32'hB00,   1'b1, 1'b1, 32'h0,        1'b1, 1'b0, 32'h0};

        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.mem_stall = 1'b0;
        drive(vecs[0], 5'd0);
        step();
        step();
        reset = 1'b0;
        check("reset_valid",  32'(bus.EXMEM_valid), 32'd0);
        check("reset_result", bus.EXMEM_alu_result, 32'd0);
        check("reset_rwv",    32'(bus.EXMEM_register_write_valid), 32'd0);
        check("reset_replace", 32'(bus.pc_replace), 32'd0);
        check("reset_stall",  32'(bus.ex_stall), 32'd0);

        // Table: each vector followed by an idle cycle so redirects never squash the next entry.
        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i], 5'(i + 1));
            bus.in_valid = 1'b1;
            step();
            bus.in_valid = 1'b0;
            check($sformatf("vec%0d_valid", i), 32'(bus.EXMEM_valid), 32'd1);
            check($sformatf("vec%0d_rd", i), 32'(bus.EXMEM_write_reg), 32'(i + 1));
            check($sformatf("vec%0d_rwv", i), 32'(bus.EXMEM_register_write_valid), 32'(vecs[i].exp_rwv));
            check($sformatf("vec%0d_replace", i), 32'(bus.pc_replace), 32'(vecs[i].exp_rep));
            if (vecs[i].chk_res)
                check($sformatf("vec%0d_result", i), bus.EXMEM_alu_result, vecs[i].exp_res);
            if (vecs[i].exp_rep)
                check($sformatf("vec%0d_target", i), bus.pc_target, vecs[i].exp_tgt);
            step();
            check($sformatf("vec%0d_bubble", i), 32'(bus.EXMEM_valid), 32'd0);
        end

        // BEQ taken, then the instruction presented during the pulse is squashed.
        v = '{OP_BRANCH, 3'd0, 1'b0, 1'b0, 32'd9, 32'd9, 32'h20, 32'h100, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h120};
        drive(v, 5'd4);
        bus.in_valid = 1'b1;
        step();
        check("beq_replace", 32'(bus.pc_replace), 32'd1);
        check("beq_target",  bus.pc_target, 32'h120);
        check("beq_rwv",     32'(bus.EXMEM_register_write_valid), 32'd0);
        drive(vecs[0], 5'd3);
        step();
        bus.in_valid = 1'b0;
        check("squash_valid",   32'(bus.EXMEM_valid), 32'd0);
        check("squash_rwv",     32'(bus.EXMEM_register_write_valid), 32'd0);
        check("squash_replace", 32'(bus.pc_replace), 32'd0);
        step();

        // MUL 0xFFFFFFFF * 3, upstream holding the instruction while stalled.
        v = '{OP_R, 3'd0, 1'b0, 1'b1, 32'hFFFFFFFF, 32'd3, 32'h0, 32'hC00, 1'b1, 1'b1, 32'hFFFFFFFD, 1'b1, 1'b0, 32'h0};
        drive(v, 5'd5);
        bus.in_valid = 1'b1;
        step();
        check("mul_accept_stall", 32'(bus.ex_stall), 32'd1);
        check("mul_accept_valid", 32'(bus.EXMEM_valid), 32'd0);
        for (int e = 1; e <= 32; e++) begin
            step();
            check($sformatf("mul_e%0d_valid", e), 32'(bus.EXMEM_valid), 32'd0);
            if (e <= 31)
                check($sformatf("mul_e%0d_stall", e), 32'(bus.ex_stall), 32'd1);
        end
        step();
        bus.in_valid = 1'b0;
        check("mul_result", bus.EXMEM_alu_result, 32'hFFFFFFFD);
        check("mul_valid",  32'(bus.EXMEM_valid), 32'd1);
        check("mul_rd",     32'(bus.EXMEM_write_reg), 32'd5);
        check("mul_rwv",    32'(bus.EXMEM_register_write_valid), 32'd1);
        check("mul_stall_after", 32'(bus.ex_stall), 32'd0);
        step();
        check("mul_then_bubble", 32'(bus.EXMEM_valid), 32'd0);

        // Same MUL abandoned by reset at cycle 10.
        drive(v, 5'd5);
        bus.in_valid = 1'b1;
        for (int e = 0; e < 10; e++) step();
        check("mulrst_busy_stall", 32'(bus.ex_stall), 32'd1);
        reset = 1'b1;
        step();
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        check("mulrst_valid",   32'(bus.EXMEM_valid), 32'd0);
        check("mulrst_result",  bus.EXMEM_alu_result, 32'd0);
        check("mulrst_stall",   32'(bus.ex_stall), 32'd0);
        check("mulrst_replace", 32'(bus.pc_replace), 32'd0);
        drive(vecs[0], 5'd3);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        check("mulrst_idle_add", bus.EXMEM_alu_result, 32'd12);
        check("mulrst_idle_valid", 32'(bus.EXMEM_valid), 32'd1);
        step();

        // SW held by three cycles of mem_stall; the following ADD waits.
        v = '{OP_STORE, 3'd2, 1'b0, 1'b0, 32'h100, 32'hDEADBEEF, 32'h8, 32'hD00, 1'b0, 1'b1, 32'h108, 1'b0, 1'b0, 32'h0};
        drive(v, 5'd0);
        bus.in_valid = 1'b1;
        step();
        check("sw_result", bus.EXMEM_alu_result, 32'h108);
        check("sw_store",  bus.EXMEM_store_data, 32'hDEADBEEF);
        check("sw_bytes",  32'(bus.EXMEM_data_write_byte), 32'hF);
        drive(vecs[0], 5'd3);
        bus.mem_stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("sw_hold%0d_result", c), bus.EXMEM_alu_result, 32'h108);
            check($sformatf("sw_hold%0d_bytes", c), 32'(bus.EXMEM_data_write_byte), 32'hF);
            check($sformatf("sw_hold%0d_valid", c), 32'(bus.EXMEM_valid), 32'd1);
            check($sformatf("sw_hold%0d_stall", c), 32'(bus.ex_stall), 32'd1);
        end
        bus.mem_stall = 1'b0;
        step();
        bus.in_valid = 1'b0;
        check("after_stall_add", bus.EXMEM_alu_result, 32'd12);
        check("after_stall_rd",  32'(bus.EXMEM_write_reg), 32'd3);
        step();

        // A redirect pulse is held by mem_stall.
        v = '{OP_JAL, 3'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h40, 32'h800, 1'b1, 1'b1, 32'h804, 1'b1, 1'b1, 32'h840};
        drive(v, 5'd1);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid  = 1'b0;
        bus.mem_stall = 1'b1;
        step();
        check("jal_hold_replace", 32'(bus.pc_replace), 32'd1);
        check("jal_hold_target",  bus.pc_target, 32'h840);
        bus.mem_stall = 1'b0;
        step();
        check("jal_release_replace", 32'(bus.pc_replace), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
